// File: rtl/dcache_refill_unit.sv
// D-cache refill engine: streams TileLink GrantData beats into the data array,
// installs the tag/state entry, then returns GrantAck on the E channel.
module dcache_refill_unit #(
  parameter  int PADDR_BITS    = 32,
  parameter  int N_SETS        = 64,
  parameter  int N_WAYS        = 8,
  parameter  int ROW_BITS      = 128,
  parameter  int REFILL_CYCLES = 4,
  parameter  int TAG_BITS      = PADDR_BITS - 12,
  parameter  int SINK_BITS     = 4,
  localparam int IDX_BITS      = $clog2(N_SETS),
  localparam int BEAT_BITS     = $clog2(REFILL_CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PADDR_BITS-1:0] req_addr,
  input  logic [N_WAYS-1:0]     req_way,
  input  logic [1:0]            req_perm,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [ROW_BITS-1:0]   d_data,
  input  logic [SINK_BITS-1:0]  d_sink,
  input  logic                  d_denied,
  output logic                  data_wvalid,
  input  logic                  data_wready,
  output logic [IDX_BITS-1:0]   data_widx,
  output logic [BEAT_BITS-1:0]  data_wbeat,
  output logic [N_WAYS-1:0]     data_wway_en,
  output logic [ROW_BITS-1:0]   data_wdata,
  output logic                  meta_wvalid,
  input  logic                  meta_wready,
  output logic [IDX_BITS-1:0]   meta_widx,
  output logic [N_WAYS-1:0]     meta_wway_en,
  output logic [TAG_BITS-1:0]   meta_wtag,
  output logic [1:0]            meta_wstate,
  output logic                  e_valid,
  input  logic                  e_ready,
  output logic [SINK_BITS-1:0]  e_sink,
  output logic                  busy,
  output logic                  done
);

  localparam int OFF_BITS = 6;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REFILL, META, ACK} state_e;

  state_e                 state_q, state_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [N_WAYS-1:0]      way_q, way_d;
  logic [1:0]             perm_q, perm_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic                   denied_q, denied_d;
  logic [SINK_BITS-1:0]   sink_q, sink_d;
  logic                   beat_fire;

  // Byte-offset bits within the 64-byte block never reach the arrays.
  logic unused_offset_bits;
  assign unused_offset_bits = ^req_addr[OFF_BITS-1:0];

  assign beat_fire = (state_q == REFILL) && d_valid && data_wready;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    way_d    = way_q;
    perm_d   = perm_q;
    beat_d   = beat_q;
    denied_d = denied_q;
    sink_d   = sink_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = REFILL;
          idx_d    = req_addr[OFF_BITS +: IDX_BITS];
          tag_d    = req_addr[PADDR_BITS-1 -: TAG_BITS];
          way_d    = req_way;
          perm_d   = req_perm;
          beat_d   = '0;
          denied_d = 1'b0;
        end
      end
      REFILL: begin
        if (beat_fire) begin
          if (beat_q == '0) sink_d = d_sink;
          denied_d = denied_q | d_denied;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = META;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end
      META:    if (meta_wready) state_d = ACK;
      ACK:     if (e_ready)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      way_q    <= '0;
      perm_q   <= '0;
      beat_q   <= '0;
      denied_q <= 1'b0;
      sink_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      way_q    <= way_d;
      perm_q   <= perm_d;
      beat_q   <= beat_d;
      denied_q <= denied_d;
      sink_q   <= sink_d;
    end
  end

  // Data path is a straight pass-through so beats land in the array with no added latency.
  assign req_ready    = (state_q == IDLE);
  assign d_ready      = (state_q == REFILL) && data_wready;
  assign data_wvalid  = (state_q == REFILL) && d_valid;
  assign data_wdata   = d_data;
  assign data_widx    = idx_q;
  assign data_wbeat   = beat_q;
  assign data_wway_en = way_q;

  assign meta_wvalid  = (state_q == META);
  assign meta_widx    = idx_q;
  assign meta_wway_en = way_q;
  assign meta_wtag    = tag_q;
  assign meta_wstate  = denied_q ? 2'b00 : perm_q;

  assign e_valid      = (state_q == ACK);
  assign e_sink       = sink_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == ACK) && e_ready;

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Self-checking bench for dcache_refill_unit: table of refill scenarios driven
// through the channels, with a scoreboard checking every array write and ack.
module tb_dcache_refill_unit;

  localparam int PADDR_BITS = 32;
  localparam int N_WAYS     = 8;
  localparam int ROW_BITS   = 128;
  localparam int SINK_BITS  = 4;
  localparam int NV         = 7;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  req_valid, req_ready;
  logic [PADDR_BITS-1:0] req_addr;
  logic [N_WAYS-1:0]     req_way;
  logic [1:0]            req_perm;
  logic                  d_valid, d_ready;
  logic [ROW_BITS-1:0]   d_data;
  logic [SINK_BITS-1:0]  d_sink;
  logic                  d_denied;
  logic                  data_wvalid, data_wready;
  logic [5:0]            data_widx;
  logic [1:0]            data_wbeat;
  logic [N_WAYS-1:0]     data_wway_en;
  logic [ROW_BITS-1:0]   data_wdata;
  logic                  meta_wvalid, meta_wready;
  logic [5:0]            meta_widx;
  logic [N_WAYS-1:0]     meta_wway_en;
  logic [19:0]           meta_wtag;
  logic [1:0]            meta_wstate;
  logic                  e_valid, e_ready;
  logic [SINK_BITS-1:0]  e_sink;
  logic                  busy, done;

  dcache_refill_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_way(req_way), .req_perm(req_perm),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_sink(d_sink),
    .d_denied(d_denied),
    .data_wvalid(data_wvalid), .data_wready(data_wready), .data_widx(data_widx),
    .data_wbeat(data_wbeat), .data_wway_en(data_wway_en), .data_wdata(data_wdata),
    .meta_wvalid(meta_wvalid), .meta_wready(meta_wready), .meta_widx(meta_widx),
    .meta_wway_en(meta_wway_en), .meta_wtag(meta_wtag), .meta_wstate(meta_wstate),
    .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]  addr;
    logic [7:0]   way;
    logic [1:0]   perm;
    logic [3:0]   sink;
    logic [127:0] data0;
    logic [3:0]   denied;
    int           dgap;
    int           stall_beat;
    int           stall_len;
    int           meta_stall;
    int           e_stall;
    bit           chain;
    logic [5:0]   exp_idx;
    logic [19:0]  exp_tag;
    logic [1:0]   exp_state;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic [5:0]   idx;
    logic [1:0]   beat;
    logic [7:0]   way;
    logic [127:0] data;
  } dexp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [7:0]  way;
    logic [19:0] tag;
    logic [1:0]  state;
  } mexp_t;

  vec_t  vecs[NV];
  dexp_t data_q[$];
  mexp_t meta_q[$];
  logic [3:0] e_q[$];
  int    lat_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc    = 0;
  int last_done_cyc = 0;
  dexp_t dm;
  mexp_t mm;
  logic [3:0] em;
  int lm;

  always @(posedge clock) cyc++;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every handshake the DUT completes is matched against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (data_wvalid && data_wready) begin
        if (data_q.size() == 0) fail_now("data_write_unexpected");
        else begin
          dm = data_q.pop_front();
          check_eq("data_widx", data_widx, dm.idx);
          check_eq("data_wbeat", data_wbeat, dm.beat);
          check_eq("data_wway_en", data_wway_en, dm.way);
          check_eq("data_wdata", data_wdata, dm.data);
        end
      end
      if (meta_wvalid && meta_wready) begin
        if (meta_q.size() == 0) fail_now("meta_write_unexpected");
        else begin
          mm = meta_q.pop_front();
          check_eq("meta_widx", meta_widx, mm.idx);
          check_eq("meta_wway_en", meta_wway_en, mm.way);
          check_eq("meta_wtag", meta_wtag, mm.tag);
          check_eq("meta_wstate", meta_wstate, mm.state);
        end
      end
      if (e_valid && e_ready) begin
        if (e_q.size() == 0) fail_now("grant_ack_unexpected");
        else begin
          em = e_q.pop_front();
          check_eq("e_sink", e_sink, em);
        end
      end
      if (done) begin
        if (lat_q.size() == 0) fail_now("done_unexpected");
        else begin
          lm = lat_q.pop_front();
          check_eq("done_latency", cyc - accept_cyc + 1, lm);
        end
        last_done_cyc = cyc;
      end
    end
  end

  task automatic wait_fire(input int ch, input string name);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clock);
      case (ch)
        0:       got = req_valid && req_ready;
        1:       got = d_valid && d_ready;
        2:       got = meta_wvalid && meta_wready;
        default: got = e_valid && e_ready;
      endcase
      step();
      n++;
    end
    if (!got) check_eq(name, 0, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    dexp_t de;
    mexp_t me;
    bit    chain_next;
    v = vecs[i];
    chain_next = (i + 1 < NV) && vecs[i+1].chain;
    for (int b = 0; b < 4; b++) begin
      de.idx  = v.exp_idx;
      de.beat = 2'(b);
      de.way  = v.way;
      de.data = v.data0 + 128'(b);
      data_q.push_back(de);
    end
    me.idx   = v.exp_idx;
    me.way   = v.way;
    me.tag   = v.exp_tag;
    me.state = v.exp_state;
    meta_q.push_back(me);
    e_q.push_back(v.sink);
    lat_q.push_back(v.exp_lat);

    req_valid = 1'b1;
    req_addr  = v.addr;
    req_way   = v.way;
    req_perm  = v.perm;
    wait_fire(0, "req_accept_timeout");
    if (v.chain) check_eq("b2b_accept_cycle", accept_cyc, last_done_cyc + 1);
    if (chain_next) begin
      req_addr = vecs[i+1].addr;
      req_way  = vecs[i+1].way;
      req_perm = vecs[i+1].perm;
    end else begin
      req_valid = 1'b0;
    end

    for (int b = 0; b < 4; b++) begin
      if (b == 1 && v.dgap > 0) begin
        d_valid = 1'b0;
        repeat (v.dgap) begin
          @(negedge clock);
          check_eq("data_wvalid_gap", data_wvalid, 0);
          step();
        end
      end
      d_valid  = 1'b1;
      d_data   = v.data0 + 128'(b);
      d_sink   = (b == 0) ? v.sink : ~v.sink;
      d_denied = v.denied[b];
      if (b == v.stall_beat) begin
        data_wready = 1'b0;
        repeat (v.stall_len) begin
          @(negedge clock);
          check_eq("d_ready_stalled", d_ready, 0);
          check_eq("stalled_beat_num", data_wbeat, b);
          step();
        end
        data_wready = 1'b1;
      end
      wait_fire(1, "beat_timeout");
    end
    d_valid  = 1'b0;
    d_denied = 1'b0;

    if (v.meta_stall > 0) begin
      meta_wready = 1'b0;
      repeat (v.meta_stall) begin
        @(negedge clock);
        check_eq("meta_wvalid_held", meta_wvalid, 1);
        check_eq("meta_wtag_held", meta_wtag, v.exp_tag);
        check_eq("meta_wstate_held", meta_wstate, v.exp_state);
        check_eq("meta_widx_held", meta_widx, v.exp_idx);
        step();
      end
      meta_wready = 1'b1;
    end
    wait_fire(2, "meta_timeout");

    if (v.e_stall > 0) begin
      e_ready = 1'b0;
      repeat (v.e_stall) begin
        @(negedge clock);
        check_eq("e_valid_held", e_valid, 1);
        check_eq("e_sink_held", e_sink, v.sink);
        check_eq("done_during_stall", done, 0);
        step();
      end
      e_ready = 1'b1;
    end
    wait_fire(3, "ack_timeout");

    if (!chain_next) begin
      @(negedge clock);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_req_ready", req_ready, 1);
      check_eq("idle_valids", {meta_wvalid, e_valid, done, d_ready}, 0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dexp_t de;
    reset       = 1'b1;
    req_valid   = 1'b1;
    req_addr    = '0;
    req_way     = '0;
    req_perm    = '0;
    d_valid     = 1'b1;
    d_data      = '0;
    d_sink      = '0;
    d_denied    = 1'b0;
    data_wready = 1'b1;
    meta_wready = 1'b1;
    e_ready     = 1'b1;

    //            addr          way    perm  sink   data0      denied  gap stb stl ms es ch idx tag       st lat
    vecs[0] = '{32'h8000_1240, 8'h04, 2'd2, 4'h3, 128'hA0,   4'b0000, 0, -1, 0, 0, 0, 0, 6'd9,  20'h80001, 2'd2, 7};
    vecs[1] = '{32'h1234_5FC0, 8'h80, 2'd1, 4'hA, 128'h1100, 4'b0000, 0,  2, 3, 0, 0, 0, 6'd63, 20'h12345, 2'd1, 10};
    vecs[2] = '{32'h0000_0040, 8'h01, 2'd3, 4'h5, 128'hB0,   4'b1000, 0, -1, 0, 0, 0, 0, 6'd1,  20'h00000, 2'd0, 7};
    vecs[3] = '{32'hFFFF_F000, 8'h10, 2'd2, 4'hF, 128'hC0,   4'b0000, 0, -1, 0, 2, 2, 0, 6'd0,  20'hFFFFF, 2'd2, 11};
    vecs[4] = '{32'hABCD_E780, 8'h02, 2'd1, 4'h7, 128'hD0,   4'b0001, 2, -1, 0, 0, 0, 0, 6'd30, 20'hABCDE, 2'd0, 9};
    vecs[5] = '{32'h5555_5A80, 8'h40, 2'd3, 4'h9, 128'hE0,   4'b0000, 0, -1, 0, 0, 0, 0, 6'd42, 20'h55555, 2'd3, 7};
    vecs[6] = '{32'h6666_6100, 8'h20, 2'd1, 4'h6, 128'hF0,   4'b0000, 0, -1, 0, 0, 0, 1, 6'd4,  20'h66666, 2'd1, 7};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valids", {data_wvalid, d_ready, meta_wvalid, e_valid, done}, 0);
    step();
    reset     = 1'b0;
    req_valid = 1'b0;
    d_valid   = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset in the middle of a refill, after beat 1 has been written.
    for (int b = 0; b < 2; b++) begin
      de.idx  = 6'd5;
      de.beat = 2'(b);
      de.way  = 8'h08;
      de.data = 128'h55 + 128'(b);
      data_q.push_back(de);
    end
    req_valid = 1'b1;
    req_addr  = 32'h0BAD_0140;
    req_way   = 8'h08;
    req_perm  = 2'd2;
    wait_fire(0, "rst_req_accept_timeout");
    req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d_valid = 1'b1;
      d_data  = 128'h55 + 128'(b);
      d_sink  = 4'h2;
      wait_fire(1, "rst_beat_timeout");
    end
    d_data = 128'h57;
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valids", {data_wvalid, d_ready, meta_wvalid, e_valid, done}, 0);
    check_eq("midrst_data_q_drained", data_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    d_valid = 1'b0;
    @(negedge clock);
    check_eq("postrst_req_ready", req_ready, 1);
    step();
    run_vec(0);

    check_eq("data_q_empty", data_q.size(), 0);
    check_eq("meta_q_empty", meta_q.size(), 0);
    check_eq("e_q_empty", e_q.size(), 0);
    check_eq("lat_q_empty", lat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
DCACHE_REFILL_UNIT -- requirements
Module: dcache_refill_unit

Interface
REQ-001 SHALL have parameter PADDR_BITS, default 32, meaning physical address width.
REQ-002 SHALL have parameter N_SETS, default 64, meaning cache sets; IDX_BITS = log2(N_SETS) = 6.
REQ-003 SHALL have parameter N_WAYS, default 8, meaning associativity; one-hot way enables.
REQ-004 SHALL have parameter ROW_BITS, default 128, meaning data-array row width, equal to one TileLink D beat.
REQ-005 SHALL have parameter REFILL_CYCLES, default 4, meaning beats per 64-byte block; BEAT_BITS = log2(REFILL_CYCLES) = 2.
REQ-006 SHALL have parameter TAG_BITS, default PADDR_BITS-12 = 20, and parameter SINK_BITS, default 4.
REQ-007 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports req_valid in 1 and req_ready out 1, refill-request handshake from the MSHR.
REQ-010 SHALL have ports req_addr in PADDR_BITS, req_way in N_WAYS (one-hot) and req_perm in 2, block address, victim way and coherence state to install.
REQ-011 SHALL have ports d_valid in 1, d_ready out 1, d_data in ROW_BITS, d_sink in SINK_BITS and d_denied in 1, TileLink GrantData beats.
REQ-012 SHALL have ports data_wvalid out 1, data_wready in 1, data_widx out IDX_BITS, data_wbeat out BEAT_BITS, data_wway_en out N_WAYS and data_wdata out ROW_BITS, data-array write port.
REQ-013 SHALL have ports meta_wvalid out 1, meta_wready in 1, meta_widx out IDX_BITS, meta_wway_en out N_WAYS, meta_wtag out TAG_BITS and meta_wstate out 2, tag-array write port.
REQ-014 SHALL have ports e_valid out 1, e_ready in 1 and e_sink out SINK_BITS, GrantAck channel.
REQ-015 SHALL have ports busy out 1, FSM not IDLE, and done out 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, REFILL, META, ACK.
REQ-017 IDLE: req_ready=1; on req_valid, latch idx=req_addr[11:6], tag=req_addr[PADDR_BITS-1:12], way, perm; clear beat counter and denied flag; go to REFILL next cycle.
REQ-018 REFILL: d_ready = data_wready; data_wvalid = d_valid; data_wdata = d_data, combinational pass-through, zero added latency.
REQ-019 SHALL count a beat only when d_valid && d_ready; data_wbeat = current counter value; data_widx and data_wway_en = latched values.
REQ-020 SHALL latch d_sink on the first accepted beat and OR d_denied of every accepted beat into the denied flag.
REQ-021 On accepting beat REFILL_CYCLES-1, counter SHALL wrap to 0 and FSM SHALL go to META.
REQ-022 META: meta_wvalid=1 with latched idx, way, tag; meta_wstate = 0 if denied flag (including a denied final beat) else latched perm; on meta_wready go to ACK.
REQ-023 ACK: e_valid=1, e_sink = latched sink; on e_ready, done=1 that cycle and go to IDLE.
REQ-024 req_ready SHALL be 0 outside IDLE; a new request SHALL be accepted no earlier than the cycle after done.
REQ-025 d_ready SHALL be 0 outside REFILL; beats stalled by data_wready=0 SHALL be neither counted nor written.
REQ-026 Minimum latency, all ready signals high: accept + 4 beat cycles + 1 META + 1 ACK = 7 cycles from req acceptance to done.
REQ-027 When not asserted, all valid, ready and done outputs SHALL be 0; address and data outputs SHALL be don't-care.

Reset
REQ-028 On reset assertion, regardless of clock, FSM SHALL go to IDLE, counter, denied flag and latched sink SHALL clear, and all valid and done outputs SHALL drop to 0.
REQ-029 Reset during REFILL/META/ACK SHALL abandon the refill with no further data, meta or E writes; the first cycle after deassertion SHALL show req_ready=1.

Verification
REQ-030 Basic refill: addr 0x8000_1240, way 0x04, perm 2, four beats 0xA0..0xA3 back-to-back -> data writes idx 9 way 0x04 beats 0..3, meta tag 0x80001 state 2, E sink echoed, done at cycle 7.
REQ-031 Backpressure: data_wready low on beat 2 for 3 cycles -> d_ready low for those cycles, exactly 4 data writes, done at cycle 10.
REQ-032 Denied: d_denied=1 on beat 3 only -> meta_wstate=0, GrantAck still sent.
REQ-033 meta_wready and e_ready each held low 2 cycles -> meta_wvalid and e_valid held stable, fields constant, single done pulse.
REQ-034 Reset asserted after beat 1 -> no meta or E write, busy=0 immediately; a following refill completes correctly from beat 0.
REQ-035 Back-to-back requests with req_valid held high -> second accepted in the cycle after done, beat counter restarts at 0.
